// File: rtl/note_glyph_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : note_glyph_blitter
//  Purpose  : Renders one 8x8 note glyph from the glyph ROM into the frame
//             buffer. It fetches a row, then emits one pixel per column with
//             off-screen clipping and a write/ready handshake.
//  Options  : NOTE_BLIT_TRANSPARENT_EN - zero bits are skipped (no write)
//             instead of being written as color 0. Timing is unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module note_glyph_blitter #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int FB_AW    = 19,
  parameter int COLOR_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [4:0]         i_req_code,
  input  logic [9:0]         i_req_x,
  input  logic [8:0]         i_req_y,
  input  logic [COLOR_W-1:0] i_req_color,
  output logic [7:0]         o_rom_addr,
  input  logic [7:0]         i_rom_data,
  output logic               o_fb_we,
  output logic [FB_AW-1:0]   o_fb_addr,
  output logic [COLOR_W-1:0] o_fb_data,
  input  logic               i_fb_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [10:0] c_SCREEN_W = 11'(SCREEN_W);
  localparam logic [9:0]  c_SCREEN_H = 10'(SCREEN_H);

  logic [1:0]         r_state;
  logic [4:0]         r_code;
  logic [9:0]         r_x;
  logic [8:0]         r_y;
  logic [COLOR_W-1:0] r_color;
  logic [2:0]         r_row;
  logic [2:0]         r_col;
  logic [7:0]         r_shreg;

  logic [10:0]        w_px;
  logic [9:0]         w_py;
  logic               w_in_bounds;
  logic               w_bit;
  logic               w_we;
  logic               w_advance;
  logic [FB_AW-1:0]   w_addr;

  // Pixel coordinates are widened by one bit so x+col / y+row never wrap.
  assign w_px        = {1'b0, r_x} + {8'b0, r_col};
  assign w_py        = {1'b0, r_y} + {7'b0, r_row};
  assign w_in_bounds = (w_px < c_SCREEN_W) && (w_py < c_SCREEN_H);
  // The shift register is pre-shifted per column, so the current bit is MSB.
  assign w_bit       = r_shreg[7];
  assign w_addr      = FB_AW'(32'(w_py) * 32'(SCREEN_W) + 32'(w_px));

`ifdef NOTE_BLIT_TRANSPARENT_EN
  assign w_we = (r_state == S_DRAW) && w_in_bounds && w_bit;
`else
  assign w_we = (r_state == S_DRAW) && w_in_bounds;
`endif

  // A skipped pixel (clipped or transparent) still costs exactly one cycle.
  assign w_advance = (r_state == S_DRAW) && (!w_we || i_fb_ready);

  assign o_req_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_rom_addr  = {r_code, r_row};
  assign o_fb_we     = w_we;
  // Outputs depend only on registered state, so they hold while stalled.
  assign o_fb_addr   = w_we ? w_addr : '0;
  assign o_fb_data   = (w_we && w_bit) ? r_color : '0;

  // Glyph sequencer: accept, fetch each row, walk its eight columns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_shreg <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_code  <= i_req_code;
            r_x     <= i_req_x;
            r_y     <= i_req_y;
            r_color <= i_req_color;
            r_row   <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_shreg <= i_rom_data;
          r_col   <= '0;
          r_state <= S_DRAW;
        end
        S_DRAW: begin
          if (w_advance) begin
            r_shreg <= {r_shreg[6:0], 1'b0};
            if (r_col == 3'd7) begin
              if (r_row == 3'd7) begin
                r_state <= S_DONE;
              end else begin
                r_row   <= r_row + 3'd1;
                r_state <= S_FETCH;
              end
            end else begin
              r_col <= r_col + 3'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
